// File: rtl/coolheat_pkg.sv
// Shared types and constants for the multi-zone cool/heat controller.
package coolheat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    DRAIN = 2'd3
  } zone_state_t;

  localparam int POWER_W = 4;
  localparam logic [POWER_W-1:0] POWER_MAX = 4'd15;

  localparam logic MODE_HEAT = 1'b1;
  localparam logic MODE_COOL = 1'b0;

endpackage

// File: rtl/coolheat_zone.sv
// One climate zone: hysteresis mode FSM, target power, ramped power register
// and registered PWM compare against the shared counter.
module coolheat_zone
  import coolheat_pkg::*;
#(
  parameter int TEMP_W = 8,
  parameter int PWM_W  = 8,
  parameter int HYST   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [PWM_W-1:0]   pwm_cnt,
  input  logic [TEMP_W-1:0]  temp,
  input  logic [TEMP_W-1:0]  setpt,
  input  logic               en,
  output logic [POWER_W-1:0] power,
  output logic               mode,
  output logic               pwm,
  output logic [1:0]         state
);

  localparam int TW1 = TEMP_W + 1;

  zone_state_t        state_reg, state_next;
  zone_state_t        pend_reg, pend_next;
  logic [POWER_W-1:0] power_reg, power_next;
  logic               mode_reg, mode_next;
  logic               pwm_reg, pwm_next;

  logic [TW1-1:0]     temp_x, setpt_x, diff;
  logic [POWER_W-1:0] diff_sat, target;
  logic               cold, hot;

  // One extra bit keeps the hysteresis sums and the difference from wrapping.
  assign temp_x   = {1'b0, temp};
  assign setpt_x  = {1'b0, setpt};
  assign diff     = (temp_x >= setpt_x) ? (temp_x - setpt_x) : (setpt_x - temp_x);
  assign cold     = (temp_x + TW1'(HYST)) < setpt_x;
  assign hot      = temp_x > (setpt_x + TW1'(HYST));
  assign diff_sat = (diff > TW1'(POWER_MAX)) ? POWER_MAX : diff[POWER_W-1:0];

  always_comb begin
    target = '0;
    if (en) begin
      case (state_reg)
        HEAT:    if (temp_x < setpt_x) target = diff_sat;
        COOL:    if (temp_x > setpt_x) target = diff_sat;
        default: target = '0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    power_next = power_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (en && cold) begin
          state_next = HEAT;
          mode_next  = MODE_HEAT;
        end else if (en && hot) begin
          state_next = COOL;
          mode_next  = MODE_COOL;
        end
      end
      HEAT, COOL: begin
        if (tick) begin
          if (power_reg < target)      power_next = power_reg + 4'd1;
          else if (power_reg > target) power_next = power_reg - 4'd1;
        end
        if (en && ((state_reg == HEAT && hot) || (state_reg == COOL && cold))) begin
          state_next = DRAIN;
          pend_next  = (state_reg == HEAT) ? COOL : HEAT;
        end else if (power_reg == '0 && target == '0) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (tick && power_reg != '0) power_next = power_reg - 4'd1;
        // Mode flips on the edge where power lands at zero, never before.
        if (power_next == '0) begin
          state_next = pend_reg;
          mode_next  = (pend_reg == HEAT) ? MODE_HEAT : MODE_COOL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pwm_next = (power_reg == POWER_MAX) ? 1'b1
                  : (pwm_cnt < (PWM_W'(power_reg) << (PWM_W - POWER_W)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= IDLE;
      power_reg <= '0;
      mode_reg  <= MODE_COOL;
      pwm_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      power_reg <= power_next;
      mode_reg  <= mode_next;
      pwm_reg   <= pwm_next;
    end
  end

  assign power = power_reg;
  assign mode  = mode_reg;
  assign pwm   = pwm_reg;
  assign state = state_reg;

endmodule

// File: rtl/multizone_coolheat_ctrl.sv
// Multi-zone cool/heat controller: shared ramp prescaler and PWM counter
// feeding ZONES independent zone instances.
module multizone_coolheat_ctrl
  import coolheat_pkg::*;
#(
  parameter int ZONES    = 4,
  parameter int TEMP_W   = 8,
  parameter int PWM_W    = 8,
  parameter int HYST     = 2,
  parameter int RAMP_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ZONES*TEMP_W-1:0]   zone_temp,
  input  logic [ZONES*TEMP_W-1:0]   zone_setpt,
  input  logic [ZONES-1:0]          zone_en,
  output logic [ZONES*POWER_W-1:0]  chs_power,
  output logic [ZONES-1:0]          chs_mode,
  output logic [ZONES-1:0]          pwm_data,
  output logic [ZONES*2-1:0]        zone_state
);

  localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [PRESC_W-1:0] presc_reg;
  logic [PWM_W-1:0]   pwm_cnt_reg;
  logic               tick;

  assign tick = (presc_reg == PRESC_W'(RAMP_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg   <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      presc_reg   <= tick ? '0 : presc_reg + 1'b1;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ZONES; gi++) begin : g_zone
      coolheat_zone #(
        .TEMP_W (TEMP_W),
        .PWM_W  (PWM_W),
        .HYST   (HYST)
      ) u_zone (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .pwm_cnt (pwm_cnt_reg),
        .temp    (zone_temp[gi*TEMP_W +: TEMP_W]),
        .setpt   (zone_setpt[gi*TEMP_W +: TEMP_W]),
        .en      (zone_en[gi]),
        .power   (chs_power[gi*POWER_W +: POWER_W]),
        .mode    (chs_mode[gi]),
        .pwm     (pwm_data[gi]),
        .state   (zone_state[gi*2 +: 2])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multizone_coolheat_ctrl.sv
// Directed bench for multizone_coolheat_ctrl with two zones and RAMP_DIV = 4.
module tb_multizone_coolheat_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] zone_temp;
  logic [15:0] zone_setpt;
  logic [1:0]  zone_en;
  logic [7:0]  chs_power;
  logic [1:0]  chs_mode;
  logic [1:0]  pwm_data;
  logic [3:0]  zone_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // clock edges since reset release; tick edges are cyc % 4 == 0

  multizone_coolheat_ctrl #(
    .ZONES(2), .TEMP_W(8), .PWM_W(8), .HYST(2), .RAMP_DIV(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .zone_temp  (zone_temp),
    .zone_setpt (zone_setpt),
    .zone_en    (zone_en),
    .chs_power  (chs_power),
    .chs_mode   (chs_mode),
    .pwm_data   (pwm_data),
    .zone_state (zone_state)
  );

  always #25 clk = ~clk;

  function automatic logic [3:0] pw(input int z);
    return chs_power[z*4 +: 4];
  endfunction

  function automatic logic [1:0] st(input int z);
    return zone_state[z*2 +: 2];
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_zone(input int z, input int t, input int s);
    zone_temp[z*8 +: 8]  = 8'(t);
    zone_setpt[z*8 +: 8] = 8'(s);
  endtask

  // Follows zone z from power 'start' toward 'tgt' with one step per tick edge.
  task automatic ramp(input int z, input int start, input int tgt, input int hold,
                      input logic m, input string name);
    int e;
    int n;
    e = start;
    n = 0;
    while (e != tgt || n < hold) begin
      step();
      if (cyc % 4 == 0 && e != tgt) e = (e < tgt) ? e + 1 : e - 1;
      if (e == tgt) n++;
      total++;
      if (pw(z) !== 4'(e)) begin
        bad++;
        $display("FAIL %s power: got %0d want %0d (cyc %0d)", name, pw(z), e, cyc);
      end
      if (e != 0) begin
        total++;
        if (chs_mode[z] !== m) begin
          bad++;
          $display("FAIL %s mode: got %0b want %0b (cyc %0d)", name, chs_mode[z], m, cyc);
        end
      end
    end
    $display("%s: reached power %0d at cyc %0d", name, e, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    zone_temp = '0; zone_setpt = '0; zone_en = '0;
    #10 rst = 1'b1;
    #5;
    total++;
    if (chs_power !== 8'd0 || chs_mode !== 2'b00 || pwm_data !== 2'b00 || zone_state !== 4'd0) begin
      bad++;
      $display("FAIL reset_async: got power=%h mode=%b pwm=%b state=%h want all 0",
               chs_power, chs_mode, pwm_data, zone_state);
    end
    step();
    step();
    total++;
    if (chs_power !== 8'd0 || chs_mode !== 2'b00 || pwm_data !== 2'b00 || zone_state !== 4'd0) begin
      bad++;
      $display("FAIL reset_held: got power=%h mode=%b pwm=%b state=%h want all 0",
               chs_power, chs_mode, pwm_data, zone_state);
    end
    rst = 1'b0;
    cyc = 0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_hysteresis();
    do_reset();
    zone_en = 2'b01;
    for (int t = 28; t <= 32; t++) begin
      set_zone(0, t, 30);
      for (int k = 0; k < 6; k++) begin
        step();
        total++;
        if (st(0) !== 2'd0 || pw(0) !== 4'd0 || pwm_data[0] !== 1'b0) begin
          bad++;
          $display("FAIL hyst_idle temp=%0d: got state=%0d power=%0d pwm=%0b want 0/0/0",
                   t, st(0), pw(0), pwm_data[0]);
        end
      end
      $display("hysteresis: temp=%0d setpt=30 stays idle", t);
    end
    set_zone(0, 27, 30);
    step();
    total++;
    if (st(0) !== 2'd1 || chs_mode[0] !== 1'b1) begin
      bad++;
      $display("FAIL hyst_cold_edge: got state=%0d mode=%0b want 1/1", st(0), chs_mode[0]);
    end
    do_reset();
    set_zone(0, 33, 30);
    step();
    total++;
    if (st(0) !== 2'd2 || chs_mode[0] !== 1'b0) begin
      bad++;
      $display("FAIL hyst_hot_edge: got state=%0d mode=%0b want 2/0", st(0), chs_mode[0]);
    end
    $display("hysteresis: temp 27 -> HEAT, temp 33 -> COOL");
  endtask

  task automatic test_heat_ramp();
    int ones;
    do_reset();
    zone_en = 2'b01;
    set_zone(0, 20, 30);
    step();
    total++;
    if (st(0) !== 2'd1 || chs_mode[0] !== 1'b1 || pw(0) !== 4'd0) begin
      bad++;
      $display("FAIL heat_enter: got state=%0d mode=%0b power=%0d want 1/1/0",
               st(0), chs_mode[0], pw(0));
    end
    ramp(0, 0, 10, 20, 1'b1, "heat_ramp");
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (pwm_data[0] === 1'b1) ones++;
    end
    total++;
    if (ones != 160) begin
      bad++;
      $display("FAIL heat_duty: got %0d/256 want 160/256", ones);
    end
    $display("heat_ramp: duty %0d/256", ones);
  endtask

  task automatic test_reversal();
    int e;
    set_zone(0, 40, 30);
    step();
    e = (cyc % 4 == 0) ? 9 : 10;
    total++;
    if (st(0) !== 2'd3 || pw(0) !== 4'(e) || chs_mode[0] !== 1'b1) begin
      bad++;
      $display("FAIL rev_drain_enter: got state=%0d power=%0d mode=%0b want 3/%0d/1",
               st(0), pw(0), chs_mode[0], e);
    end
    ramp(0, e, 0, 0, 1'b1, "rev_drain");
    if (st(0) !== 2'd2) step();
    total++;
    if (st(0) !== 2'd2 || chs_mode[0] !== 1'b0 || pw(0) !== 4'd0) begin
      bad++;
      $display("FAIL rev_cool_enter: got state=%0d mode=%0b power=%0d want 2/0/0",
               st(0), chs_mode[0], pw(0));
    end
    ramp(0, 0, 10, 4, 1'b0, "rev_cool_ramp");
  endtask

  task automatic test_saturation();
    int e;
    set_zone(0, 0, 60);
    step();
    e = (cyc % 4 == 0) ? 9 : 10;
    total++;
    if (st(0) !== 2'd3 || pw(0) !== 4'(e)) begin
      bad++;
      $display("FAIL sat_drain_enter: got state=%0d power=%0d want 3/%0d", st(0), pw(0), e);
    end
    ramp(0, e, 0, 0, 1'b0, "sat_drain");
    if (st(0) !== 2'd1) step();
    total++;
    if (st(0) !== 2'd1 || chs_mode[0] !== 1'b1) begin
      bad++;
      $display("FAIL sat_heat_enter: got state=%0d mode=%0b want 1/1", st(0), chs_mode[0]);
    end
    ramp(0, 0, 15, 4, 1'b1, "sat_ramp");
    for (int k = 0; k < 300; k++) begin
      step();
      total++;
      if (pwm_data[0] !== 1'b1 || pw(0) !== 4'd15) begin
        bad++;
        $display("FAIL sat_pwm: got pwm=%0b power=%0d want 1/15 (cyc %0d)",
                 pwm_data[0], pw(0), cyc);
      end
    end
    $display("saturation: power 15, pwm held high");
  endtask

  task automatic test_disable();
    int n;
    int e;
    logic exp_pwm1;
    do_reset();
    set_zone(0, 22, 30);
    set_zone(1, 50, 45);
    zone_en = 2'b11;
    n = 0;
    while (!(pw(0) == 4'd8 && pw(1) == 4'd5) && n < 100) begin
      step();
      n++;
    end
    total++;
    if (pw(0) !== 4'd8 || pw(1) !== 4'd5 || st(1) !== 2'd2) begin
      bad++;
      $display("FAIL dis_setup: got p0=%0d p1=%0d s1=%0d want 8/5/2", pw(0), pw(1), st(1));
    end
    zone_en = 2'b10;
    e = 8;
    while (e > 0) begin
      step();
      if (cyc % 4 == 0) e--;
      exp_pwm1 = (((cyc - 1) % 256) < 80);
      total++;
      if (pw(0) !== 4'(e) || chs_mode[0] !== 1'b1) begin
        bad++;
        $display("FAIL dis_ramp0: got power=%0d mode=%0b want %0d/1", pw(0), chs_mode[0], e);
      end
      total++;
      if (pw(1) !== 4'd5 || st(1) !== 2'd2 || chs_mode[1] !== 1'b0 || pwm_data[1] !== exp_pwm1) begin
        bad++;
        $display("FAIL dis_iso1: got p=%0d s=%0d m=%0b pwm=%0b want 5/2/0/%0b",
                 pw(1), st(1), chs_mode[1], pwm_data[1], exp_pwm1);
      end
    end
    if (st(0) !== 2'd0) step();
    total++;
    if (st(0) !== 2'd0 || chs_mode[0] !== 1'b1) begin
      bad++;
      $display("FAIL dis_idle: got state=%0d mode=%0b want 0/1", st(0), chs_mode[0]);
    end
    step();
    total++;
    if (pwm_data[0] !== 1'b0 || pw(0) !== 4'd0) begin
      bad++;
      $display("FAIL dis_pwm0: got pwm=%0b power=%0d want 0/0", pwm_data[0], pw(0));
    end
    $display("disable: zone0 idle at cyc %0d, zone1 unaffected", cyc);
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    set_zone(0, 20, 30);
    set_zone(1, 0, 0);
    zone_en = 2'b01;
    n = 0;
    while (pw(0) != 4'd3 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (pw(0) !== 4'd3) begin
      bad++;
      $display("FAIL arst_setup: got power=%0d want 3", pw(0));
    end
    #5 rst = 1'b1;
    #1;
    total++;
    if (chs_power !== 8'd0 || chs_mode !== 2'b00 || pwm_data !== 2'b00 || zone_state !== 4'd0) begin
      bad++;
      $display("FAIL arst_immediate: got power=%h mode=%b pwm=%b state=%h want all 0",
               chs_power, chs_mode, pwm_data, zone_state);
    end
    cyc = 0;
    step();
    rst = 1'b0;
    cyc = 0;
    step();
    total++;
    if (st(0) !== 2'd1 || chs_mode[0] !== 1'b1 || pw(0) !== 4'd0) begin
      bad++;
      $display("FAIL arst_restart: got state=%0d mode=%0b power=%0d want 1/1/0",
               st(0), chs_mode[0], pw(0));
    end
    ramp(0, 0, 3, 0, 1'b1, "arst_ramp");
  endtask

  initial begin
    test_reset();
    test_hysteresis();
    test_heat_ramp();
    test_reversal();
    test_saturation();
    test_disable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
